// File: rtl/sha256_pkg.sv
// Shared SHA-256 controller definitions: round/message constants, round index type
// and the controller state encoding used by the round controller and its neighbours.
package sha256_pkg;

    localparam int NUM_ROUNDS = 64;
    localparam int MSG_WORDS  = 16;
    localparam int IDX_W      = 6;

    typedef logic [IDX_W-1:0] round_idx_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        ROUND  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: clears on block init, advances on each executed round,
// flags the last round and the message-load (schedule) phase.
module sha256_round_counter #(
    parameter int IDX_W      = sha256_pkg::IDX_W,
    parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
    parameter int MSG_WORDS  = sha256_pkg::MSG_WORDS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] count,
    output logic             term,
    output logic             sched
);

    assign term  = (count == IDX_W'(NUM_ROUNDS - 1));
    assign sched = (count < IDX_W'(MSG_WORDS));

    // Round index register; wraps to zero after the final round.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= {IDX_W{1'b0}};
        end else if (clear) begin
            count <= {IDX_W{1'b0}};
        end else if (enable) begin
            count <= term ? {IDX_W{1'b0}} : count + IDX_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one 512-bit block per start, driving message reads,
// schedule load/expand, round enables, working-variable init and hash accumulate.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
    parameter int MSG_WORDS  = sha256_pkg::MSG_WORDS,
    parameter int IDX_W      = sha256_pkg::IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             first_block,
    input  logic             last_block,
    input  logic             msg_valid,
    output logic             msg_rd,
    output logic [3:0]       msg_addr,
    output logic             w_load,
    output logic             w_expand,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             init_iv,
    output logic             init_work,
    output logic             hash_update,
    output logic             busy,
    output logic             block_done,
    output logic             done
);
    import sha256_pkg::*;

    ctrl_state_t state_r;
    ctrl_state_t state_nxt_s;
    logic        first_r;
    logic        last_r;
    logic        cnt_clear_s;
    logic        cnt_term_s;
    logic        cnt_sched_s;

    sha256_round_counter #(
        .IDX_W      (IDX_W),
        .NUM_ROUNDS (NUM_ROUNDS),
        .MSG_WORDS  (MSG_WORDS)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear_s),
        .enable (round_en),
        .count  (round_idx),
        .term   (cnt_term_s),
        .sched  (cnt_sched_s)
    );

    assign cnt_clear_s = (state_r == INIT);
    assign msg_addr    = round_idx[3:0];

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Block flags are captured only when a start is accepted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            first_r <= first_block;
            last_r  <= last_block;
        end else begin
            first_r <= first_r;
            last_r  <= last_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? INIT : IDLE;
            INIT:    state_nxt_s = ROUND;
            ROUND:   state_nxt_s = (round_en && cnt_term_s) ? UPDATE : ROUND;
            UPDATE:  state_nxt_s = last_r ? DONE : IDLE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; during message rounds a missing word stalls the round.
    always_comb begin
        msg_rd      = 1'b0;
        w_load      = 1'b0;
        w_expand    = 1'b0;
        round_en    = 1'b0;
        init_iv     = 1'b0;
        init_work   = 1'b0;
        hash_update = 1'b0;
        busy        = 1'b0;
        block_done  = 1'b0;
        done        = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            INIT: begin
                busy      = 1'b1;
                init_iv   = first_r;
                init_work = ~first_r;
            end
            ROUND: begin
                busy = 1'b1;
                if (cnt_sched_s) begin
                    msg_rd   = 1'b1;
                    w_load   = msg_valid;
                    round_en = msg_valid;
                end else begin
                    w_expand = 1'b1;
                    round_en = 1'b1;
                end
            end
            UPDATE: begin
                busy        = 1'b1;
                hash_update = 1'b1;
                block_done  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: cycle-exact output checks over single, stalled,
// multi-block, ignored-start and reset-abort scenarios.
module tb_sha256_round_ctrl;
    import sha256_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       first_block;
    logic       last_block;
    logic       msg_valid;
    logic       msg_rd;
    logic [3:0] msg_addr;
    logic       w_load;
    logic       w_expand;
    logic       round_en;
    logic [5:0] round_idx;
    logic       init_iv;
    logic       init_work;
    logic       hash_update;
    logic       busy;
    logic       block_done;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sha256_round_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .first_block (first_block),
        .last_block  (last_block),
        .msg_valid   (msg_valid),
        .msg_rd      (msg_rd),
        .msg_addr    (msg_addr),
        .w_load      (w_load),
        .w_expand    (w_expand),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .init_iv     (init_iv),
        .init_work   (init_work),
        .hash_update (hash_update),
        .busy        (busy),
        .block_done  (block_done),
        .done        (done)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ctl order: msg_rd w_load w_expand round_en init_iv init_work hash_update busy block_done done
    task automatic expect_outs(input string tag, input logic [9:0] ctl,
                               input logic [3:0] addr, input logic [5:0] idx);
        logic [19:0] obs;
        logic [19:0] exp;
        obs = {msg_rd, w_load, w_expand, round_en, init_iv, init_work,
               hash_update, busy, block_done, done, msg_addr, round_idx};
        exp = {ctl, addr, idx};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // One block from start to idle. Negative round arguments disable that feature.
    task automatic run_block(input string tag, input logic first, input logic last,
                             input int stall_round, input int stall_len,
                             input int pulse_round, input int abort_round);
        logic       sc;
        logic [5:0] tv;
        start       = 1'b1;
        first_block = first;
        last_block  = last;
        msg_valid   = 1'b1;
        step();
        start       = 1'b0;
        first_block = ~first;
        last_block  = ~last;
        #1;
        expect_outs({tag, "_init"}, {4'b0000, first, ~first, 4'b0100}, 4'd0, 6'd0);
        step();
        for (int t = 0; t < 64; t++) begin
            tv = t[5:0];
            sc = (t < 16);
            if (t == abort_round) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                #1;
                expect_outs({tag, "_abort"}, 10'b0000000000, 4'd0, 6'd0);
                return;
            end
            if (t == stall_round) begin
                for (int s = 0; s < stall_len; s++) begin
                    msg_valid = 1'b0;
                    #1;
                    expect_outs({tag, "_stall"}, 10'b1000000100, tv[3:0], tv);
                    step();
                end
                msg_valid = 1'b1;
            end
            if (t == pulse_round) begin
                start       = 1'b1;
                first_block = ~first;
                last_block  = ~last;
            end
            #1;
            expect_outs({tag, "_round"}, {sc, sc, ~sc, 1'b1, 6'b000100}, tv[3:0], tv);
            step();
            start = 1'b0;
        end
        expect_outs({tag, "_update"}, 10'b0000001110, 4'd0, 6'd0);
        step();
        if (last) begin
            expect_outs({tag, "_done"}, 10'b0000000101, 4'd0, 6'd0);
            step();
        end
        expect_outs({tag, "_idle"}, 10'b0000000000, 4'd0, 6'd0);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        first_block = 1'b0;
        last_block  = 1'b0;
        msg_valid   = 1'b0;
        step();
        step();
        expect_outs("reset_state", 10'b0000000000, 4'd0, 6'd0);
        reset     = 1'b1;
        msg_valid = 1'b1;
        step();
        expect_outs("idle_no_start", 10'b0000000000, 4'd0, 6'd0);

        run_block("single", 1'b1, 1'b1, -1, 0, -1, -1);
        run_block("stall", 1'b1, 1'b1, 5, 3, -1, -1);
        run_block("blk1", 1'b1, 1'b0, -1, 0, -1, -1);
        run_block("blk2", 1'b0, 1'b1, -1, 0, -1, -1);
        run_block("ign_start", 1'b1, 1'b1, -1, 0, 30, -1);
        run_block("abort", 1'b1, 1'b1, -1, 0, -1, 40);
        run_block("after_abort", 1'b1, 1'b1, -1, 0, -1, -1);

        reset       = 1'b0;
        start       = 1'b1;
        first_block = 1'b1;
        last_block  = 1'b1;
        step();
        expect_outs("rst_with_start", 10'b0000000000, 4'd0, 6'd0);
        reset = 1'b1;
        run_block("post_rst", 1'b1, 1'b1, -1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
